// File: rtl/button_debouncer.sv
// Multi-channel button debouncer and edge detector.
// Each channel: N-flop synchroniser -> FILTER_LEN-sample shift register -> debounced level.
// The level drives registered press/release pulses. A per-channel down-counter drives the
// auto-repeat strobe. Every output comes straight from a flop.

module button_debouncer #(
  parameter int unsigned CHANNELS      = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_LEN    = 8,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] buttons_i,
  input  logic [CHANNELS-1:0] repeat_en_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] strobe_o
);

  // Elaboration-time parameter checks.
  if (CHANNELS < 1) begin : g_chk_channels
    $fatal(1, "button_debouncer: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "button_debouncer: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 2) begin : g_chk_filter
    $fatal(1, "button_debouncer: FILTER_LEN must be >= 2");
  end
  if (REPEAT_DELAY < 1) begin : g_chk_delay
    $fatal(1, "button_debouncer: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_period
    $fatal(1, "button_debouncer: REPEAT_PERIOD must be >= 1");
  end

  localparam int unsigned RepMax =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW = $clog2(RepMax + 1);

  localparam logic [CntW-1:0] DelayLd  = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] PeriodLd = CntW'(REPEAT_PERIOD);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILTER_LEN-1:0]  r_filt;
    logic [CntW-1:0]        r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_strobe;

    logic                   w_sync_out;
    logic                   w_all_ones;
    logic                   w_all_zeros;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_rep_active;
    logic                   w_rep_fire;
    logic                   w_level_next;
    logic [CntW-1:0]        w_cnt_next;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: bit 0 samples the raw pin, the top bit feeds the filter.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], buttons_i[c]};
      end
    end

    // Filter shift register: holds the last FILTER_LEN synchronised samples.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_filt <= '0;
      end else begin
        r_filt <= {r_filt[FILTER_LEN-2:0], w_sync_out};
      end
    end

    // Level decision, edge detection and repeat counter next-state.
    always_comb begin
      w_all_ones   = &r_filt;
      w_all_zeros  = ~|r_filt;
      w_rise       = w_all_ones & ~r_level;
      w_fall       = w_all_zeros & r_level;
      w_rep_active = r_level & repeat_en_i[c];
      w_rep_fire   = 1'b0;
      w_cnt_next   = DelayLd;
      w_level_next = r_level;

      if (w_rise) begin
        w_level_next = 1'b1;
      end else if (w_fall) begin
        w_level_next = 1'b0;
      end

      if (w_rep_active) begin
        // The <= also covers the post-reset zero, though level cannot be high then.
        if (r_cnt <= CntOne) begin
          w_rep_fire = 1'b1;
          w_cnt_next = PeriodLd;
        end else begin
          w_cnt_next = r_cnt - CntOne;
        end
      end

      // A release on the same edge as a repeat wins; the counter goes back to idle.
      if (w_fall) begin
        w_rep_fire = 1'b0;
        w_cnt_next = DelayLd;
      end
    end

    // Registered level, pulses and repeat counter.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_strobe  <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_level   <= w_level_next;
        r_press   <= w_rise;
        r_release <= w_fall;
        r_strobe  <= w_rise | w_rep_fire;
        r_cnt     <= w_cnt_next;
      end
    end

    assign level_o[c]   = r_level;
    assign press_o[c]   = r_press;
    assign release_o[c] = r_release;
    assign strobe_o[c]  = r_strobe;

  end

endmodule
